// File: rtl/i2c_slave_regfile.sv
// I2C target with a 16x8 register file: write via address/register/data phases,
// read back over the bus with auto-incrementing pointer, plus a host-side read port.
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'b1010101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  // [0] first sync flop, [1] synced value, [2] history of the synced value
  logic [2:0] scl_sync_q, sda_sync_q;
  logic       scl, scl_prev, sda, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] rd_byte_q;
  logic [3:0] ptr_q;
  logic       rw_q;
  logic       ack_phase_q;
  logic       sda_out_q;
  logic       wr_strobe_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       busy_q;
  logic [7:0] regs_q [16];

  logic [7:0] rx_byte_d;
  logic [3:0] ptr_inc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], SCL_in};
      sda_sync_q <= {sda_sync_q[1:0], SDA_in};
    end
  end

  assign scl       = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda       = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & sda_prev & ~sda;
  assign stop_det  = scl & ~sda_prev & sda;

  assign rx_byte_d = {shift_q, sda};
  assign ptr_inc_d = ptr_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_byte_q   <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_out_q   <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_det) begin
        state_q   <= S_IDLE;
        sda_out_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        state_q     <= S_ADDR;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        sda_out_q   <= 1'b1;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          S_ADDR, S_REG, S_WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (state_q == S_ADDR) begin
                  if (rx_byte_d[7:1] == DEV_ADDR) begin
                    state_q <= S_ADDR_ACK;
                    rw_q    <= rx_byte_d[0];
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_REG) begin
                  ptr_q   <= rx_byte_d[3:0];
                  state_q <= S_REG_ACK;
                end else begin
                  regs_q[ptr_q] <= rx_byte_d;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= rx_byte_d;
                  wr_strobe_q   <= 1'b1;
                  ptr_q         <= ptr_inc_d;
                  state_q       <= S_WDATA_ACK;
                end
              end
            end
          end
          // First fall after the 8th bit pulls SDA low; the following fall ends the ACK.
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_out_q   <= 1'b0;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                if (state_q == S_ADDR_ACK && rw_q) begin
                  sda_out_q <= regs_q[ptr_q][7];
                  rd_byte_q <= regs_q[ptr_q];
                  bit_cnt_q <= 4'd1;
                  state_q   <= S_RDATA;
                end else begin
                  sda_out_q <= 1'b1;
                  state_q   <= (state_q == S_ADDR_ACK) ? S_REG : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_out_q <= 1'b1;
                state_q   <= S_RDATA_ACK;
              end else begin
                sda_out_q <= rd_byte_q[3'd7 - bit_cnt_q[2:0]];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr_q     <= ptr_inc_d;
                rd_byte_q <= regs_q[ptr_inc_d];
                bit_cnt_q <= '0;
                state_q   <= S_RDATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA_out   = sda_out_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign rd_data   = regs_q[rd_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a behavioural I2C master drives directed and random
// transactions; a register/pointer model predicts ACKs, read bytes and write strobes.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCL_in = 1'b1;
  logic       SDA_in = 1'b1;
  logic       SDA_out;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;

  i2c_slave_regfile #(.DEV_ADDR(7'h55)) dut (
    .clk(clk), .rst(rst), .SCL_in(SCL_in), .SDA_in(SDA_in), .SDA_out(SDA_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_regs [16];
  logic [3:0]  m_ptr;
  logic [7:0]  wbuf [8];
  logic [11:0] exp_wr_q [$];
  logic [11:0] obs_wr_q [$];
  int          sda_low_cycles = 0;
  int          strobe_long = 0;
  logic        strobe_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (wr_strobe) obs_wr_q.push_back({wr_addr, wr_data});
    if (wr_strobe && strobe_prev) strobe_long++;
    strobe_prev = wr_strobe;
    if (SDA_out === 1'b0) sda_low_cycles++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: SDA set mid-low, slave output sampled late in the high phase.
  task automatic send_bit(input logic b, output logic seen);
    clk_wait(4); SDA_in = b;
    clk_wait(4); SCL_in = 1'b1;
    clk_wait(7); seen = SDA_out;
    clk_wait(1); SCL_in = 1'b0;
  endtask

  task automatic bus_start();
    clk_wait(4); SDA_in = 1'b1;
    clk_wait(4); SCL_in = 1'b1;
    clk_wait(8); SDA_in = 1'b0;
    clk_wait(8); SCL_in = 1'b0;
  endtask

  task automatic bus_stop();
    clk_wait(4); SDA_in = 1'b0;
    clk_wait(4); SCL_in = 1'b1;
    clk_wait(8); SDA_in = 1'b1;
    clk_wait(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic drove);
    logic s;
    drove = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], s);
      if (!s) drove = 1'b1;
    end
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(master_nack, s);
  endtask

  task automatic check_strobes();
    check_eq("strobe count", 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
    while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0)
      check_eq("strobe addr/data", 32'(obs_wr_q.pop_front()), 32'(exp_wr_q.pop_front()));
    obs_wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check_eq($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic do_write(input logic [7:0] reg_byte, input int n);
    logic ack, drove, any_drove;
    $display("txn: write reg=0x%02h bytes=%0d", reg_byte, n);
    bus_start();
    check_eq("busy after start", 32'(busy), 32'd1);
    write_byte(8'hAA, ack, drove); any_drove = drove;
    check_eq("write addr ack", 32'(ack), 32'd0);
    write_byte(reg_byte, ack, drove); any_drove |= drove;
    check_eq("write reg ack", 32'(ack), 32'd0);
    m_ptr = reg_byte[3:0];
    for (int k = 0; k < n; k++) begin
      write_byte(wbuf[k], ack, drove); any_drove |= drove;
      check_eq("write data ack", 32'(ack), 32'd0);
      m_regs[m_ptr] = wbuf[k];
      exp_wr_q.push_back({m_ptr, wbuf[k]});
      m_ptr = m_ptr + 4'd1;
    end
    bus_stop();
    check_eq("no drive in data bits", 32'(any_drove), 32'd0);
    check_eq("busy after stop", 32'(busy), 32'd0);
    check_strobes();
    check_regs();
  endtask

  task automatic do_read(input logic with_reg, input logic [7:0] reg_byte, input int n);
    logic ack, drove;
    logic [7:0] d;
    $display("txn: read with_reg=%0d reg=0x%02h bytes=%0d", with_reg, reg_byte, n);
    bus_start();
    if (with_reg) begin
      write_byte(8'hAA, ack, drove);
      check_eq("read addr(W) ack", 32'(ack), 32'd0);
      write_byte(reg_byte, ack, drove);
      check_eq("read reg ack", 32'(ack), 32'd0);
      m_ptr = reg_byte[3:0];
      bus_start();
    end
    write_byte(8'hAB, ack, drove);
    check_eq("read addr(R) ack", 32'(ack), 32'd0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      check_eq($sformatf("read byte %0d", k), 32'(d), 32'(m_regs[m_ptr]));
      if (k < n - 1) m_ptr = m_ptr + 4'd1;
    end
    clk_wait(6);
    check_eq("released after nack", 32'(SDA_out), 32'd1);
    bus_stop();
    check_eq("busy after stop", 32'(busy), 32'd0);
    check_strobes();
  endtask

  task automatic do_mismatch(input logic [7:0] addr_byte, input int n);
    logic ack, drove;
    $display("txn: foreign address byte=0x%02h bytes=%0d", addr_byte, n);
    sda_low_cycles = 0;
    bus_start();
    write_byte(addr_byte, ack, drove);
    check_eq("mismatch addr nack", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      write_byte(8'($urandom_range(0, 255)), ack, drove);
      check_eq("mismatch data nack", 32'(ack), 32'd1);
    end
    bus_stop();
    check_eq("mismatch sda never low", 32'(sda_low_cycles), 32'd0);
    check_strobes();
    check_regs();
  endtask

  initial begin
    logic ack, drove, s;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 4'd0;

    #2 rst = 1'b0;
    clk_wait(4);
    $display("txn: reset values");
    check_eq("reset SDA_out", 32'(SDA_out), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("reset wr_addr", 32'(wr_addr), 32'd0);
    check_eq("reset wr_data", 32'(wr_data), 32'd0);
    check_regs();
    rst = 1'b1;
    clk_wait(10);

    wbuf[0] = 8'h55;
    do_write(8'hD5, 1);
    do_mismatch(8'hA8, 2);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h0F, 2);
    do_read(1'b1, 8'h05, 2);

    $display("txn: stop in the middle of a data byte");
    bus_start();
    write_byte(8'hAA, ack, drove);
    check_eq("partial addr ack", 32'(ack), 32'd0);
    write_byte(8'h03, ack, drove);
    check_eq("partial reg ack", 32'(ack), 32'd0);
    m_ptr = 4'd3;
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    send_bit(1'b1, s); send_bit(1'b0, s);
    bus_stop();
    check_eq("partial busy after stop", 32'(busy), 32'd0);
    check_strobes();
    check_regs();

    for (int t = 0; t < 24; t++) begin
      int kind, n;
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      case (kind)
        0: begin
          for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
          do_write(8'($urandom_range(0, 255)), n);
        end
        1: do_read(1'b1, 8'($urandom_range(0, 255)), n);
        2: do_read(1'b0, 8'h00, n);
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h55) a = 7'h54;
          do_mismatch({a, 1'($urandom_range(0, 1))}, n);
        end
      endcase
    end

    $display("txn: reset during address ACK");
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'hAA;
      send_bit(ab[i], s);
    end
    clk_wait(4); SDA_in = 1'b1;
    clk_wait(4); SCL_in = 1'b1;
    clk_wait(7);
    check_eq("ack low before reset", 32'(SDA_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_eq("SDA_out released by reset", 32'(SDA_out), 32'd1);
    check_eq("busy cleared by reset", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 4'd0;
    clk_wait(3);
    rst = 1'b1;
    check_regs();
    clk_wait(1); SCL_in = 1'b0;
    write_byte(8'hAA, ack, drove);
    check_eq("idle after reset ignores byte", 32'(ack), 32'd1);
    bus_stop();
    wbuf[0] = 8'h9C; wbuf[1] = 8'h3E;
    do_write(8'h07, 2);
    do_read(1'b0, 8'h00, 2);

    check_eq("strobe width", 32'(strobe_long), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
